mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Consumer of the decoded control word in the MEM stage of the LC-3b pipeline. Sequences data-memory
//  accesses per opcode: word/byte loads/stores, two-access indirect LDI/STI, and the TRAP vector fetch.
//  Drives the data-memory request/response port, stalls the pipeline until the access completes,
//  and returns aligned load data to WB. Non-memory opcodes pass through with zero added latency.
// PARAMETERS
//  ADDR_W  16  data-memory address width (bits)
//  DATA_W  16  data-memory word width (bits); byte-lane count = DATA_W/8 = 2
// PORTS
//  clk              in   1       single clock; all state updates on rising edge
//  rst_n            in   1       synchronous, active-low reset
//  valid_in         in   1       MEM-stage instruction valid
//  opcode           in   4       ctrl.opcode (lc3b_opcode) of MEM-stage instruction
//  addr_in          in   ADDR_W  effective address from EX (ALU result / trap vector address)
//  store_data       in   DATA_W  SR value to store (STR/STB/STI)
//  mem_resp         in   1       memory done: read data valid / write accepted, this cycle
//  mem_rdata        in   DATA_W  memory read data
//  mem_read         out  1       read request, held until mem_resp
//  mem_write        out  1       write request, held until mem_resp
//  mem_address      out  ADDR_W  request address, bit 0 always 0
//  mem_wdata        out  DATA_W  write data
//  mem_byte_enable  out  2       write lane enables
//  stall            out  1       freeze upstream pipeline registers
//  wb_data          out  DATA_W  load result / trap vector, valid when stall==0
//  misalign         out  1       only with MEM_ALIGN_CHECK_EN; see CONFIGURATION
// BEHAVIOUR
//  Reset: state=IDLE; mem_read=mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=2'b00,
//   stall=0, wb_data=0, misalign=0. Reset mid-access drops the request that same edge; no retry.
//  Memops: LDR LDB LDI STR STB STI TRAP. Other opcodes or valid_in=0: stall=0, no request, wb_data held.
//  States: IDLE -> ACC1 -> [ACC2] -> DONE -> IDLE.
//   IDLE: valid_in & memop -> stall=1 combinationally in this cycle; latch opcode/addr/data; next ACC1.
//   ACC1: LDR/LDB/TRAP=read, STR/STB=write, LDI/STI=read pointer. Request held with stable address/data
//    until mem_resp; on mem_resp go DONE, or ACC2 for LDI/STI (pointer := mem_rdata).
//   ACC2: LDI reads word at pointer, STI writes store_data at pointer; on mem_resp go DONE.
//   DONE: stall=0, requests low, wb_data valid; instruction leaves MEM at end of this cycle; next IDLE.
//  Latency: RA+2 cycles for single-access ops (RA = request-to-resp cycles, >=1); RA1+RA2+2 for LDI/STI.
//  mem_resp seen in IDLE/DONE is ignored. Request signals change only on state entry.
//  Word ops: mem_address = {addr[ADDR_W-1:1],1'b0}; byte_enable=2'b11.
//  STB: mem_wdata={sd[7:0],sd[7:0]}; byte_enable = addr[0] ? 2'b10 : 2'b01.
//  LDB: wb_data = zero-extend(addr[0] ? rdata[15:8] : rdata[7:0]). LDR/LDI/TRAP: wb_data = rdata.
//  Stores: wb_data unchanged. Reads drive byte_enable=2'b00.
//  Indirect pointer: bit 0 of the fetched pointer is forced to 0.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: LDR/STR/LDI/STI with addr_in[0]=1 (or odd LDI/STI pointer) issue no
//   (further) request; go directly to DONE, wb_data=0, misalign=1 for the DONE cycle only.
//  Undefined: misalign tied 0; bit 0 silently cleared as above. Byte ops never misalign.
// STRUCTURE
//  lc3b_types package: lc3b_word, lc3b_opcode (existing); add mem_state_t {IDLE,ACC1,ACC2,DONE},
//   and an is_memop(opcode) function for use by the hazard logic.
//  Sub-module mem_byte_lane (combinational): STB lane replication/enable, LDB extract/zero-extend.
// TESTING
//  LDR addr=0x3001, rdata=0xBEEF, resp after 2 cycles -> address 0x3000, stall 4 cycles, wb_data=0xBEEF.
//  STB addr=0x2001, sd=0x00A5 -> mem_write, wdata=0xA5A5, byte_enable=2'b10, no wb_data change.
//  LDB addr=0x2001, rdata=0x8012 -> wb_data=0x0080; addr 0x2000 -> wb_data=0x0012.
//  LDI addr=0x4000, ptr=0x5000, data=0x1234 -> two reads 0x4000 then 0x5000, wb_data=0x1234.
//  STI mid-ACC2 rst_n=0 -> next edge: IDLE, mem_write=0, stall=0; ADD next -> no request, stall=0.
//  MEM_ALIGN_CHECK_EN: STR addr=0x3003 -> no mem_write, misalign=1 one cycle; undefined: write 0x3002.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// LC-3b shared types plus MEM-stage sequencer state and opcode class helpers.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'd0,  op_add = 4'd1,  op_ldb = 4'd2,  op_stb  = 4'd3,
    op_jsr  = 4'd4,  op_and = 4'd5,  op_ldr = 4'd6,  op_str  = 4'd7,
    op_rti  = 4'd8,  op_not = 4'd9,  op_ldi = 4'd10, op_sti  = 4'd11,
    op_jmp  = 4'd12, op_shf = 4'd13, op_lea = 4'd14, op_trap = 4'd15
  } lc3b_opcode;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} mem_state_t;

  function automatic logic is_memop(lc3b_opcode op);
    return op inside {op_ldr, op_ldb, op_ldi, op_str, op_stb, op_sti, op_trap};
  endfunction

  // Ops that are subject to word-alignment checking.
  function automatic logic is_word_op(lc3b_opcode op);
    return op inside {op_ldr, op_str, op_ldi, op_sti};
  endfunction

  function automatic logic is_indirect(lc3b_opcode op);
    return op inside {op_ldi, op_sti};
  endfunction

  // First access is a write only for direct stores; STI first reads its pointer.
  function automatic logic is_direct_store(lc3b_opcode op);
    return op inside {op_str, op_stb};
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_byte_lane.sv
// Byte-lane helper: STB replication / lane enable and LDB extract with zero-extension.
module mem_byte_lane #(
  parameter int DATA_W = 16
) (
  input  logic                  byte_sel,
  input  logic [7:0]            sd_byte,
  input  logic [DATA_W-1:0]     rdata,
  output logic [DATA_W-1:0]     st_wdata,
  output logic [DATA_W/8-1:0]   st_be,
  output logic [DATA_W-1:0]     ld_data
);
  localparam int LANES = DATA_W / 8;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign st_wdata[i*8 +: 8] = sd_byte;
    assign st_be[i]           = (int'(byte_sel) == i);
  end

  assign ld_data = {{(DATA_W-8){1'b0}}, rdata[8*int'(byte_sel) +: 8]};

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory sequencer for LC-3b loads/stores/LDI/STI/TRAP.
// Optional MEM_ALIGN_CHECK_EN: odd word addresses abort to DONE with misalign=1.
module mem_stage_ctrl
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_in,
  input  logic [3:0]          opcode,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic [DATA_W-1:0]   store_data,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_byte_enable,
  output logic                stall,
  output logic [DATA_W-1:0]   wb_data,
  output logic                misalign
);
  mem_state_t          state, state_n;
  lc3b_opcode          op_in, op_q;
  logic                byte_q, byte_sel;
  logic [DATA_W-1:0]   sd_q;
  logic                start, mis_in, mis_ptr, misalign_q;
  logic [ADDR_W-1:0]   ptr;
  logic [DATA_W-1:0]   lane_wdata, lane_ldata;
  logic [DATA_W/8-1:0] lane_be;

  assign op_in    = lc3b_opcode'(opcode);
  assign start    = valid_in && is_memop(op_in);
  assign ptr      = ADDR_W'({mem_rdata[DATA_W-1:1], 1'b0});
  assign byte_sel = (state == IDLE) ? addr_in[0] : byte_q;
  assign misalign = misalign_q;

`ifdef MEM_ALIGN_CHECK_EN
  assign mis_in  = is_word_op(op_in) && addr_in[0];
  assign mis_ptr = mem_rdata[0];
`else
  assign mis_in  = 1'b0;
  assign mis_ptr = 1'b0;
`endif

  mem_byte_lane #(.DATA_W(DATA_W)) u_lane (
    .byte_sel (byte_sel),
    .sd_byte  (store_data[7:0]),
    .rdata    (mem_rdata),
    .st_wdata (lane_wdata),
    .st_be    (lane_be),
    .ld_data  (lane_ldata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    case (state)
      IDLE: if (start) begin
        stall   = 1'b1;
        state_n = mis_in ? DONE : ACC1;
      end
      ACC1: begin
        stall = 1'b1;
        if (mem_resp) state_n = (is_indirect(op_q) && !mis_ptr) ? ACC2 : DONE;
      end
      ACC2: begin
        stall = 1'b1;
        if (mem_resp) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request outputs are registered and only move on state entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q            <= op_br;
      byte_q          <= 1'b0;
      sd_q            <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      wb_data         <= '0;
      misalign_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q   <= op_in;
          byte_q <= addr_in[0];
          sd_q   <= store_data;
          if (mis_in) begin
            misalign_q <= 1'b1;
            wb_data    <= '0;
          end else begin
            mem_address     <= {addr_in[ADDR_W-1:1], 1'b0};
            mem_read        <= !is_direct_store(op_in);
            mem_write       <= is_direct_store(op_in);
            mem_wdata       <= (op_in == op_stb) ? lane_wdata : store_data;
            mem_byte_enable <= !is_direct_store(op_in) ? '0 :
                               (op_in == op_stb) ? lane_be : '1;
          end
        end
        ACC1: if (mem_resp) begin
          if (is_indirect(op_q) && !mis_ptr) begin
            mem_address     <= ptr;
            mem_read        <= (op_q == op_ldi);
            mem_write       <= (op_q == op_sti);
            mem_wdata       <= sd_q;
            mem_byte_enable <= (op_q == op_sti) ? '1 : '0;
          end else begin
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
            if (is_indirect(op_q)) begin
              misalign_q <= 1'b1;
              wb_data    <= '0;
            end else if (op_q == op_ldb) begin
              wb_data <= lane_ldata;
            end else if (!is_direct_store(op_q)) begin
              wb_data <= mem_rdata;
            end
          end
        end
        ACC2: if (mem_resp) begin
          mem_read        <= 1'b0;
          mem_write       <= 1'b0;
          mem_byte_enable <= '0;
          if (op_q == op_ldi) wb_data <= mem_rdata;
        end
        DONE:    misalign_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl against a transaction-level memory/ISA model.
module tb_mem_stage_ctrl;
  localparam logic [3:0] OP_ADD = 4'd1,  OP_LDB = 4'd2,  OP_STB = 4'd3,  OP_LDR = 4'd6;
  localparam logic [3:0] OP_STR = 4'd7,  OP_LDI = 4'd10, OP_STI = 4'd11, OP_TRAP = 4'd15;
  localparam logic [16:0] NOLIT = 17'h0;

  logic clk = 1'b0;
  logic rst_n, valid_in, mem_resp;
  logic [3:0]  opcode;
  logic [15:0] addr_in, store_data, mem_rdata;
  logic        mem_read, mem_write, stall, misalign;
  logic [15:0] mem_address, mem_wdata, wb_data;
  logic [1:0]  mem_byte_enable;

  mem_stage_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode(opcode),
    .addr_in(addr_in), .store_data(store_data), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .stall(stall), .wb_data(wb_data),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  logic        cmp_en = 1'b0;
  logic        exp_stall, exp_rd, exp_wr, exp_mis;
  logic [15:0] exp_addr, exp_wdata, exp_wb;
  logic [1:0]  exp_be;
  int          stall_cnt = 0, wr_cnt = 0, mis_cnt = 0;
  logic [15:0] last_raddr = '0, prev_raddr = '0, last_waddr = '0, last_wdata = '0;
  logic [1:0]  last_be = '0;
  logic        rd_d = 1'b0, wr_d = 1'b0, resp_d = 1'b0;
  logic [15:0] mem_m [logic [15:0]];

  function automatic logic [15:0] mrd(input logic [15:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {a[7:0], a[15:8]} ^ 16'h6B39;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Per-cycle comparison plus a small monitor of request starts.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("stall", stall, exp_stall);
      chk("mem_read", mem_read, exp_rd);
      chk("mem_write", mem_write, exp_wr);
      chk("wb_data", wb_data, exp_wb);
      chk("misalign", misalign, exp_mis);
      if (exp_rd || exp_wr) begin
        chk("mem_address", mem_address, exp_addr);
        chk("byte_enable", mem_byte_enable, exp_be);
        if (exp_wr) chk("mem_wdata", mem_wdata, exp_wdata);
      end
    end
    if (stall) stall_cnt++;
    if (misalign) mis_cnt++;
    if (mem_read && (!rd_d || resp_d)) begin prev_raddr = last_raddr; last_raddr = mem_address; end
    if (mem_write && (!wr_d || resp_d)) begin
      wr_cnt++; last_waddr = mem_address; last_wdata = mem_wdata; last_be = mem_byte_enable;
    end
    rd_d = mem_read; wr_d = mem_write; resp_d = mem_resp;
  end

  // One memory access: request held for lat cycles, response on the last one.
  task automatic access(input logic w, input logic [15:0] ea, input logic [15:0] wd,
                        input logic [1:0] be, input int lat, output logic [15:0] rdv);
    int L;
    logic [15:0] m;
    L = (lat > 0) ? lat : int'($urandom_range(1, 4));
    rdv = mrd(ea);
    for (int c = 1; c <= L; c++) begin
      exp_stall = 1'b1; exp_rd = !w; exp_wr = w;
      exp_addr = ea; exp_wdata = wd; exp_be = be;
      mem_resp  = (c == L);
      mem_rdata = (c == L) ? rdv : 16'($urandom);
      @(posedge clk); #1;
    end
    mem_resp = 1'b0;
    if (w) begin
      m = mrd(ea);
      if (be[1]) m[15:8] = wd[15:8];
      if (be[0]) m[7:0]  = wd[7:0];
      mem_m[ea] = m;
    end
  endtask

  task automatic done_cycle(input logic [15:0] w, input logic m, input logic [16:0] lit,
                            input int lit_stall);
    exp_stall = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_wb = w; exp_mis = m;
    mem_resp  = ($urandom_range(0, 1) == 1);   // must be ignored in DONE
    mem_rdata = 16'($urandom);
    @(negedge clk); #1;
    if (lit[16]) chk("literal_wb", wb_data, {16'h0, lit[15:0]});
    if (lit_stall > 0) chk("stall_cycles", stall_cnt, lit_stall);
    @(posedge clk); #1;
    mem_resp = 1'b0;
  endtask

  task automatic run_op(input logic v, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] sd, input int lat, input logic abort,
                        input logic [16:0] lit, input int lit_stall);
    logic memop, w1;
    logic [15:0] rdv, p, wb;
    logic [1:0] be;
    valid_in = v; opcode = op; addr_in = a; store_data = sd;
    mem_resp  = ($urandom_range(0, 3) == 0);     // must be ignored in IDLE
    mem_rdata = 16'($urandom);
    memop = v && (op inside {OP_LDB, OP_STB, OP_LDR, OP_STR, OP_LDI, OP_STI, OP_TRAP});
    exp_stall = memop; exp_rd = 1'b0; exp_wr = 1'b0; exp_mis = 1'b0;
    stall_cnt = 0;
    @(posedge clk); #1;
    mem_resp = 1'b0;
    if (!memop) return;
    wb = exp_wb;
`ifdef MEM_ALIGN_CHECK_EN
    if ((op inside {OP_LDR, OP_STR, OP_LDI, OP_STI}) && a[0]) begin
      done_cycle(16'h0, 1'b1, lit, lit_stall);
      return;
    end
`endif
    w1 = (op == OP_STR) || (op == OP_STB);
    be = !w1 ? 2'b00 : (op == OP_STB) ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
    access(w1, {a[15:1], 1'b0}, (op == OP_STB) ? {sd[7:0], sd[7:0]} : sd, be, lat, rdv);
    case (op)
      OP_LDR, OP_TRAP: wb = rdv;
      OP_LDB:          wb = {8'h00, a[0] ? rdv[15:8] : rdv[7:0]};
      OP_LDI, OP_STI: begin
`ifdef MEM_ALIGN_CHECK_EN
        if (rdv[0]) begin
          done_cycle(16'h0, 1'b1, lit, lit_stall);
          return;
        end
`endif
        p = {rdv[15:1], 1'b0};
        if (abort) begin
          exp_stall = 1'b1; exp_rd = (op == OP_LDI); exp_wr = (op == OP_STI);
          exp_addr = p; exp_wdata = sd; exp_be = (op == OP_STI) ? 2'b11 : 2'b00;
          mem_resp = 1'b0; rst_n = 1'b0;
          @(posedge clk); #1;
          rst_n = 1'b1; exp_wb = 16'h0; exp_mis = 1'b0;
          return;
        end
        if (op == OP_LDI) begin access(1'b0, p, sd, 2'b00, lat, rdv); wb = rdv; end
        else access(1'b1, p, sd, 2'b11, lat, rdv);
      end
      default: ;
    endcase
    done_cycle(wb, 1'b0, lit, lit_stall);
  endtask

  initial begin
    int w0, m0;
    rst_n = 1'b0; valid_in = 1'b0; opcode = '0; addr_in = '0; store_data = '0;
    mem_resp = 1'b0; mem_rdata = '0; exp_wb = '0; exp_mis = 1'b0;
    exp_stall = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 0);           chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);   chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wdata", mem_wdata, 0);   chk("rst_byte_enable", mem_byte_enable, 0);
    chk("rst_wb_data", wb_data, 0);       chk("rst_misalign", misalign, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; cmp_en = 1'b1;

    mem_m[16'h3000] = 16'hBEEF;
    mem_m[16'h4000] = 16'h5000;
    mem_m[16'h5000] = 16'h1234;
    mem_m[16'h4100] = 16'h5100;

    run_op(1, OP_LDR, 16'h3001, 16'h0, 3, 0, {1'b1, 16'hBEEF}, 4);
    chk("ldr_addr", last_raddr, 16'h3000);
    run_op(1, OP_STB, 16'h2001, 16'h00A5, 2, 0, {1'b1, 16'hBEEF}, 0);
    chk("stb_wdata", last_wdata, 16'hA5A5);
    chk("stb_be", last_be, 2'b10);
    mem_m[16'h2000] = 16'h8012;
    run_op(1, OP_LDB, 16'h2001, 16'h0, 1, 0, {1'b1, 16'h0080}, 0);
    run_op(1, OP_LDB, 16'h2000, 16'h0, 2, 0, {1'b1, 16'h0012}, 0);
    run_op(1, OP_LDI, 16'h4000, 16'h0, 2, 0, {1'b1, 16'h1234}, 0);
    chk("ldi_first_read", prev_raddr, 16'h4000);
    chk("ldi_second_read", last_raddr, 16'h5000);

    w0 = wr_cnt; m0 = mis_cnt;
    run_op(1, OP_STR, 16'h3003, 16'hCAFE, 1, 0, NOLIT, 0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("str_odd_no_write", wr_cnt - w0, 0);
    chk("str_odd_misalign_cycles", mis_cnt - m0, 1);
`else
    chk("str_odd_write", wr_cnt - w0, 1);
    chk("str_odd_addr", last_waddr, 16'h3002);
`endif

    run_op(1, OP_STI, 16'h4100, 16'h7777, 2, 1, NOLIT, 0);
    run_op(1, OP_ADD, 16'h4100, 16'h0, 0, 0, NOLIT, 0);
    chk("post_reset_mem_read", mem_read, 0);

    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h6000 + 16'($urandom_range(0, 31));
      run_op($urandom_range(0, 9) != 0, 4'($urandom_range(0, 15)), a, 16'($urandom),
             0, 0, NOLIT, 0);
    end

    cmp_en = 1'b0; valid_in = 1'b0;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
